axi_line_arbiter: RTL
=====================

// Module: axi_line_arbiter
// PURPOSE
//  N-port successor to the two-port cache memory bus. Arbitrates cache-line fill and writeback requests from
//  NUM_PORTS caches (I$, D$, PTW, ...) onto a single AXI4 master port, one line per transaction, as INCR bursts.
//  Forwards snoop (AC) addresses to all caches as a one-cycle invalidate pulse. Sits between the caches and top-level m_axi_*.
// PARAMETERS
//  NUM_PORTS   2   number of requesting caches (>=1)
//  ID_WIDTH    13  AXI ID width; IDs carry the granted port index, zero-extended
//  ADDR_WIDTH  64  address width
//  DATA_WIDTH  64  AXI beat width
//  LINE_BEATS  16  beats per cache line; LINE_BITS = DATA_WIDTH*LINE_BEATS
// PORTS
//  clk              in   1                     clock
//  reset            in   1                     synchronous, active-low reset
//  req_valid        in   NUM_PORTS             port p requests a line transfer
//  req_store        in   NUM_PORTS             1 = writeback, 0 = fill
//  req_addr         in   NUM_PORTS*ADDR_WIDTH  byte address; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata        in   NUM_PORTS*LINE_BITS   writeback line; port p at [p*LINE_BITS +: LINE_BITS]
//  req_grant        out  NUM_PORTS             one-hot, 1-cycle pulse when port's request is captured
//  resp_valid       out  NUM_PORTS             transfer for port p complete; held until resp_ready[p]
//  resp_ready       in   NUM_PORTS             port p accepts response
//  resp_rdata       out  LINE_BITS             fill data (shared), valid with resp_valid
//  resp_err         out  1                     any beat had RRESP/BRESP != 0; valid with resp_valid
//  invalidate       out  1                     1-cycle snoop invalidate pulse to all caches
//  invalidate_addr  out  ADDR_WIDTH            snooped address, valid with invalidate
//  m_axi_aw*/w*/b*  -    AXI4 write channels, widths as top; AWID/AWADDR/AWVALID/WDATA/WLAST/WVALID/BREADY driven
//  m_axi_ar*/r*     -    AXI4 read channels, widths as top; ARID/ARADDR/ARVALID/RREADY driven
//  m_axi_ac*        -    ACVALID/ACADDR/ACSNOOP in, ACREADY out
//  constants: {AW,AR}LEN=LINE_BEATS-1, SIZE=$clog2(DATA_WIDTH/8), BURST=2'b01, LOCK/CACHE/PROT=0, WSTRB=all 1s
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, rr pointer=0; all valids, req_grant, resp_*, invalidate, RREADY, BREADY=0.
//    Reset mid-burst abandons the transaction; no further AXI handshakes driven.
//  - FSM: IDLE -> (fill) AR -> R -> RESP -> IDLE ; IDLE -> (store) AW -> W -> B -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant lowest port >= rr pointer (round robin, wraps); latch addr/store/wdata,
//    pulse req_grant[g], rr <= g+1 mod NUM_PORTS. Requests dropped before grant are ignored.
//  - Address sent line-aligned (low $clog2(LINE_BITS/8) bits zeroed); ID = g.
//  - AR/AW: VALID held until READY; next state on handshake. ADDR/ID stable while VALID.
//  - R: RREADY=1; beat k written to line buffer [k*DATA_WIDTH +: DATA_WIDTH]; beat counter wraps at LINE_BEATS;
//    leave on RLAST handshake regardless of count. RRESP!=0 sets sticky err for this transaction.
//  - W: beat k = latched wdata slice k; WLAST on beat LINE_BEATS-1; WVALID held until WREADY; AW before W.
//  - B: BREADY=1; leave on BVALID; BRESP!=0 sets err.
//  - RESP: resp_valid[g]=1, resp_rdata=line buffer (stale for stores), resp_err=err; leave when resp_ready[g].
//    Earliest new grant is the cycle after resp handshake (one transaction outstanding).
//  - Min fill latency (slave always ready, 1-cycle data): grant c0, ARVALID c1, beats c2..c1+LINE_BEATS, resp_valid next.
//  - Snoop: ACREADY=1 always; on ACVALID, next cycle invalidate=1, invalidate_addr=ACADDR; independent of FSM.
//    Back-to-back snoops give back-to-back pulses. A fill to the snooped line completes normally (caches resolve).
// TESTING
//  1 Fill: port0 req addr 0x8000_0123, slave returns beats 0..15 = i -> ARADDR 0x8000_0100, ARID 0, resp_rdata[k*64+:64]=k, resp_err 0.
//  2 Writeback: port1 store 0x1040 data beat k=0xA0+k, WREADY toggling -> 16 W beats in order, WLAST only on 16th, AWID 1.
//  3 Contention: ports 0,1 hold req_valid for 4 transfers -> grants alternate 0,1,0,1; no port starved.
//  4 Error/backpressure: ARREADY low 5 cycles, RRESP=2 on beat 3 -> ARVALID/ARADDR stable, resp_err 1, resp_ready low 3 cycles holds resp_valid.
//  5 Reset mid-R after 7 beats, plus snoop ACADDR 0x2000 during fill -> invalidate pulse at 0x2000 next cycle; after reset all outputs 0, IDLE, rr=0.

Source files
------------

// File: rtl/axi_line_arbiter.sv
// axi_line_arbiter: round-robin arbiter that moves whole cache lines between NUM_PORTS caches
// and a single AXI4 master port, one INCR burst per transaction, one transaction outstanding.
// Also forwards snoop addresses (AC channel) to all caches as a one-cycle invalidate pulse.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   req_*                      per-port line requests (valid/store/addr/wdata) and grant pulse
//   resp_*                     per-port completion handshake, shared fill data and error flag
//   invalidate*                snoop invalidate pulse and address
//   m_axi_aw*/w*/b*            AXI4 write channels
//   m_axi_ar*/r*               AXI4 read channels
//   m_axi_ac*                  snoop address channel
module axi_line_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LINE_BEATS = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_PORTS-1:0]                       req_valid,
  input  logic [NUM_PORTS-1:0]                       req_store,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]            req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH*LINE_BEATS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]                       req_grant,
  output logic [NUM_PORTS-1:0]                       resp_valid,
  input  logic [NUM_PORTS-1:0]                       resp_ready,
  output logic [DATA_WIDTH*LINE_BEATS-1:0]           resp_rdata,
  output logic                                       resp_err,
  output logic                                       invalidate,
  output logic [ADDR_WIDTH-1:0]                      invalidate_addr,
  output logic [ID_WIDTH-1:0]                        m_axi_awid,
  output logic [ADDR_WIDTH-1:0]                      m_axi_awaddr,
  output logic [7:0]                                 m_axi_awlen,
  output logic [2:0]                                 m_axi_awsize,
  output logic [1:0]                                 m_axi_awburst,
  output logic                                       m_axi_awlock,
  output logic [3:0]                                 m_axi_awcache,
  output logic [2:0]                                 m_axi_awprot,
  output logic                                       m_axi_awvalid,
  input  logic                                       m_axi_awready,
  output logic [DATA_WIDTH-1:0]                      m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]                    m_axi_wstrb,
  output logic                                       m_axi_wlast,
  output logic                                       m_axi_wvalid,
  input  logic                                       m_axi_wready,
  input  logic [ID_WIDTH-1:0]                        m_axi_bid,
  input  logic [1:0]                                 m_axi_bresp,
  input  logic                                       m_axi_bvalid,
  output logic                                       m_axi_bready,
  output logic [ID_WIDTH-1:0]                        m_axi_arid,
  output logic [ADDR_WIDTH-1:0]                      m_axi_araddr,
  output logic [7:0]                                 m_axi_arlen,
  output logic [2:0]                                 m_axi_arsize,
  output logic [1:0]                                 m_axi_arburst,
  output logic                                       m_axi_arlock,
  output logic [3:0]                                 m_axi_arcache,
  output logic [2:0]                                 m_axi_arprot,
  output logic                                       m_axi_arvalid,
  input  logic                                       m_axi_arready,
  input  logic [ID_WIDTH-1:0]                        m_axi_rid,
  input  logic [DATA_WIDTH-1:0]                      m_axi_rdata,
  input  logic [1:0]                                 m_axi_rresp,
  input  logic                                       m_axi_rlast,
  input  logic                                       m_axi_rvalid,
  output logic                                       m_axi_rready,
  input  logic                                       m_axi_acvalid,
  input  logic [ADDR_WIDTH-1:0]                      m_axi_acaddr,
  input  logic [3:0]                                 m_axi_acsnoop,
  output logic                                       m_axi_acready
);

  localparam int unsigned LineBits = DATA_WIDTH * LINE_BEATS;
  localparam int unsigned PortW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned BeatW    = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned OffW     = $clog2(LineBits / 8);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAr   = 3'd1;
  localparam logic [2:0] StR    = 3'd2;
  localparam logic [2:0] StAw   = 3'd3;
  localparam logic [2:0] StW    = 3'd4;
  localparam logic [2:0] StB    = 3'd5;
  localparam logic [2:0] StResp = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [PortW-1:0]      rr_q, rr_d;
  logic [PortW-1:0]      gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LineBits-1:0]   wdata_q, wdata_d;
  logic [LineBits-1:0]   line_q, line_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  inv_q;
  logic [ADDR_WIDTH-1:0] inv_addr_q;

  logic                  found;
  logic [PortW-1:0]      pick;
  logic [PortW-1:0]      idx;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic                  beat_last;

  // These inputs carry nothing this single-outstanding master needs.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_acsnoop};

  // Round robin: first requesting port at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = PortW'((int'(rr_q) + i) % NUM_PORTS);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pick_addr = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
  assign beat_last = (beat_q == BeatW'(LINE_BEATS - 1));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    beat_d  = beat_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = pick;
          rr_d    = (pick == PortW'(NUM_PORTS - 1)) ? '0 : pick + 1'b1;
          addr_d  = {pick_addr[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
          wdata_d = req_wdata[pick*LineBits +: LineBits];
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = req_store[pick] ? StAw : StAr;
        end
      end
      StAr: if (m_axi_arready) state_d = StR;
      StR: begin
        if (m_axi_rvalid) begin
          line_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
          beat_d = beat_last ? '0 : beat_q + 1'b1;
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          if (m_axi_rlast) state_d = StResp;
        end
      end
      StAw: if (m_axi_awready) state_d = StW;
      StW: begin
        if (m_axi_wready) begin
          beat_d = beat_last ? '0 : beat_q + 1'b1;
          if (beat_last) state_d = StB;
        end
      end
      StB: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
          state_d = StResp;
        end
      end
      StResp: if (resp_ready[gnt_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      inv_q      <= 1'b0;
      inv_addr_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      // Snoop path runs regardless of the transfer FSM.
      inv_q   <= m_axi_acvalid;
      if (m_axi_acvalid) inv_addr_q <= m_axi_acaddr;
    end
  end

  // Grant is suppressed while reset is asserted since the capture would be discarded.
  always_comb begin
    req_grant  = '0;
    resp_valid = '0;
    if (state_q == StIdle && found && reset) req_grant[pick] = 1'b1;
    if (state_q == StResp) resp_valid[gnt_q] = 1'b1;
  end

  assign resp_rdata      = line_q;
  assign resp_err        = err_q;
  assign invalidate      = inv_q;
  assign invalidate_addr = inv_addr_q;

  assign m_axi_awid    = ID_WIDTH'(gnt_q);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'(LINE_BEATS - 1);
  assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0000;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = (state_q == StAw);
  assign m_axi_wdata   = wdata_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_q == StW) && beat_last;
  assign m_axi_wvalid  = (state_q == StW);
  assign m_axi_bready  = (state_q == StB);

  assign m_axi_arid    = ID_WIDTH'(gnt_q);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(LINE_BEATS - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == StAr);
  assign m_axi_rready  = (state_q == StR);

  assign m_axi_acready = 1'b1;

endmodule
